// File: rtl/pulse_sequencer.sv
// pulse_sequencer: table-driven output pattern sequencer.
// A table of NUM_STEPS entries {dur, pattern, trig} is played out step by step.
// Each step holds for dur+1 cycles. Passes repeat loop_count times, or forever when loop_count is 0.
// Optional macro PULSE_SEQ_EXT_START_EN enables the ext_start pin. The pin is
// synchronized and its rising edge is treated as a start request.
module pulse_sequencer #(
  parameter int                NUM_STEPS    = 16,
  parameter int                DUR_W        = 22,
  parameter int                OUT_W        = 8,
  parameter logic [OUT_W-1:0]  IDLE_PATTERN = OUT_W'(8'b1000_0001),
  localparam int               IDX_W        = $clog2(NUM_STEPS)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [OUT_W-1:0] cfg_pattern,
  input  logic             cfg_trig,
  input  logic [IDX_W-1:0] last_step,
  input  logic [15:0]      loop_count,
  input  logic             start,
  input  logic             stop,
  input  logic             ext_start,
  output logic [OUT_W-1:0] signal_out,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_index
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Step table
  logic [DUR_W-1:0]     r_tab_dur [NUM_STEPS];
  logic [OUT_W-1:0]     r_tab_pat [NUM_STEPS];
  logic [NUM_STEPS-1:0] r_tab_trig;

  // Sequencer state
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DUR_W-1:0] r_timer;
  logic [15:0]      r_pass;
  logic [15:0]      r_loop;
  logic [IDX_W-1:0] r_last;
  logic [OUT_W-1:0] r_sig;
  logic             r_trig;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic             w_addr_ok;
  logic [IDX_W-1:0] w_last_clamp;
  logic [15:0]      w_pass_inc;
  logic             w_at_last;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_finish;

`ifdef PULSE_SEQ_EXT_START_EN
  logic r_ext_s1, r_ext_s2, r_ext_d;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
      r_ext_d  <= 1'b0;
    end else begin
      r_ext_s1 <= ext_start;
      r_ext_s2 <= r_ext_s1;
      r_ext_d  <= r_ext_s2;
    end
  end

  assign w_start = start | (r_ext_s2 & ~r_ext_d);
`else
  logic w_unused_ext;
  assign w_unused_ext = ext_start;
  assign w_start      = start;
`endif

  // Writes with an out-of-range address are dropped.
  // This only matters when NUM_STEPS is not a power of two.
  assign w_addr_ok    = 32'(cfg_addr) < 32'(NUM_STEPS);
  assign w_last_clamp = (32'(last_step) >= 32'(NUM_STEPS)) ? IDX_W'(NUM_STEPS - 1) : last_step;
  // The pass counter saturates so that free-running loops never wrap it
  assign w_pass_inc   = (r_pass == 16'hFFFF) ? r_pass : r_pass + 16'd1;
  assign w_at_last    = (r_idx == r_last);
  assign w_nxt_idx    = w_at_last ? '0 : r_idx + IDX_W'(1);
  assign w_finish     = w_at_last && (r_loop != 16'd0) && (w_pass_inc == r_loop);

  // Table write port; reset restores every entry to a zero-length idle step
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tab_dur[i] <= '0;
        r_tab_pat[i] <= IDLE_PATTERN;
      end
      r_tab_trig <= '0;
    end else if (cfg_we && w_addr_ok) begin
      r_tab_dur[cfg_addr]  <= cfg_dur;
      r_tab_pat[cfg_addr]  <= cfg_pattern;
      r_tab_trig[cfg_addr] <= cfg_trig;
    end
  end

  // IDLE/RUN sequencer with registered outputs.
  // A step read uses the pre-edge table contents, so a same-edge write takes effect on the next visit.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_timer <= '0;
      r_pass  <= '0;
      r_loop  <= '0;
      r_last  <= '0;
      r_sig   <= IDLE_PATTERN;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start && !stop) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_pass  <= '0;
            r_loop  <= loop_count;
            r_last  <= w_last_clamp;
            r_timer <= r_tab_dur[0];
            r_sig   <= r_tab_pat[0];
            r_trig  <= r_tab_trig[0];
          end
        end
        S_RUN: begin
          if (stop || (r_timer == '0 && w_finish)) begin
            // Abort or normal completion. Only completion pulses done.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_timer <= '0;
            r_pass  <= '0;
            r_sig   <= IDLE_PATTERN;
            r_done  <= !stop;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - DUR_W'(1);
          end else begin
            if (w_at_last) r_pass <= w_pass_inc;
            r_idx   <= w_nxt_idx;
            r_timer <= r_tab_dur[w_nxt_idx];
            r_sig   <= r_tab_pat[w_nxt_idx];
            r_trig  <= r_tab_trig[w_nxt_idx];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign signal_out = r_sig;
  assign trigger    = r_trig;
  assign busy       = r_busy;
  assign done       = r_done;
  assign step_index = r_idx;

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 16, number of table steps (2..64); IDX_W = clog2(NUM_STEPS).
REQ-002 Parameter DUR_W, default 22, width of step duration field and internal timer.
REQ-003 Parameter OUT_W, default 8, width of signal_out pattern.
REQ-004 Parameter IDLE_PATTERN, default 8'b1000_0001 (zero-extended to OUT_W), output pattern when not running.
REQ-005 clk_in  input  1  sole clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cfg_we  input  1  table write strobe.
REQ-008 cfg_addr  input  IDX_W  table entry to write.
REQ-009 cfg_dur  input  DUR_W  step duration value; step lasts cfg_dur+1 cycles.
REQ-010 cfg_pattern  input  OUT_W  step output pattern.
REQ-011 cfg_trig  input  1  step emits trigger on entry.
REQ-012 last_step  input  IDX_W  index of final step in a pass.
REQ-013 loop_count  input  16  passes per run; 0 = run until stop.
REQ-014 start  input  1  level-sampled run request.
REQ-015 stop  input  1  abort request.
REQ-016 ext_start  input  1  asynchronous hardware start (see Configuration).
REQ-017 signal_out  output  OUT_W  registered pattern.
REQ-018 trigger  output  1  one-cycle step-entry pulse.
REQ-019 busy  output  1  high while in RUN.
REQ-020 done  output  1  one-cycle pulse on normal completion.
REQ-021 step_index  output  IDX_W  current step.

Function
REQ-022 Two states, IDLE and RUN; all outputs registered.
REQ-023 Table: NUM_STEPS entries of {dur, pattern, trig}; cfg_we writes entry cfg_addr at the clock edge, in any state.
REQ-024 IDLE -> RUN when start sampled high (and stop low); next cycle signal_out = pattern[0], step_index = 0, busy = 1, trigger = trig[0].
REQ-025 On step entry dur is latched; step holds exactly dur+1 cycles, then advances to step_index+1.
REQ-026 After last_step, step_index wraps to 0 and pass counter increments; if last_step >= NUM_STEPS, wrap occurs at NUM_STEPS-1.
REQ-027 trigger asserts only the first cycle of a step whose trig bit is set; dur = 0 steps on consecutive cycles each produce their own trigger pulse.
REQ-028 When pass counter reaches loop_count (nonzero) at end of last_step: next cycle RUN -> IDLE, signal_out = IDLE_PATTERN, busy = 0, done = 1 for one cycle, step_index = 0.
REQ-029 stop high in RUN: next cycle IDLE, signal_out = IDLE_PATTERN, no done pulse; stop wins over simultaneous start.
REQ-030 start while busy is ignored; loop_count and last_step are latched at run start.
REQ-031 Write to the entry being entered on the same edge: old contents are used for that entry.
REQ-032 Timer and pass counter never overflow silently: loop_count = 0 pass counter saturates at 0xFFFF.

Reset
REQ-033 rst_n low immediately forces IDLE, signal_out = IDLE_PATTERN, trigger = 0, busy = 0, done = 0, step_index = 0, timer and pass counter = 0.
REQ-034 Reset clears table: dur = 0, pattern = IDLE_PATTERN, trig = 0; reset mid-run aborts without done.

Configuration
REQ-035 Macro PULSE_SEQ_EXT_START_EN defined: ext_start passes a 2-flop synchronizer; its rising edge acts as start (3-cycle latency from pin to RUN entry).
REQ-036 Macro undefined: ext_start port present but ignored; only start initiates a run.

Verification
REQ-037 Table {dur 3,pat 0x89,trig 0},{dur 0,pat 0x85,trig 1}, last_step 1, loop_count 1, start pulse -> 0x89 for 4 cycles, 0x85 1 cycle with trigger, then IDLE_PATTERN and done = 1.
REQ-038 loop_count 0, same table, stop after 20 cycles -> pattern repeats period 5, IDLE next cycle, done never asserted.
REQ-039 Three dur = 0 steps all trig = 1 -> trigger high three consecutive cycles.
REQ-040 rst_n low mid-step 1 -> outputs reset asynchronously, table reads back zero durations on next run.
REQ-041 start and stop same cycle in IDLE -> remains IDLE, busy 0.
REQ-042 With PULSE_SEQ_EXT_START_EN, ext_start rising edge -> busy high 3 cycles later; without macro -> no run.
